// File: rtl/commit_trace_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_tx_pkg
// Description : Shared types and constants for the commit-trace transmitter:
//               the trace record layout, the transmitter state encoding and
//               the default buffer depth.
// Revision    : 1.0 - initial release
// ============================================================================
package commit_trace_tx_pkg;

  localparam int XLEN        = 32;
  localparam int XWIDTH      = 5;
  localparam int TRACE_DEPTH = 4;

  // One retired instruction as seen by a trace sink. seq is first so that the
  // most significant bits of the flattened record carry the ordering key.
  typedef struct packed {
    logic [31:0]       seq;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic              rd_we;
    logic [XWIDTH-1:0] rd;
    logic [XLEN-1:0]   rd_data;
    logic              mem_re;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_data;
    logic              halt;
  } trace_rec_t;

  localparam int TRACE_REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    TR_RUN        = 2'd0,
    TR_HALT_DRAIN = 2'd1,
    TR_HALTED     = 2'd2
  } trace_state_e;

endpackage : commit_trace_tx_pkg
`default_nettype wire

// File: rtl/commit_trace_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_tx_fifo
// Description : Synchronous FIFO of trace records with occupancy count.
//               The head record reads as zero whenever the FIFO is empty so
//               the downstream interface presents a clean bus when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_tx_fifo
  import commit_trace_tx_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  trace_rec_t         data_i,
  output trace_rec_t         head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [AW:0]        count_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  trace_rec_t        mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q,  count_d;
  logic              w_push;
  logic              w_pop;

  assign full_o  = (count_q == FULL_LVL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({w_push, w_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset flushes the FIFO.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are don't-care until written, head is masked.
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : commit_trace_tx_fifo
`default_nettype wire

// File: rtl/commit_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_tx
// Description : Retirement-trace transmitter. Formats one record per retired
//               instruction, buffers it, and streams it out on a valid/ready
//               interface. Tracks overflow drops and the halt/drain sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_tx
  import commit_trace_tx_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   enable_i,
  input  logic                   retire_valid_i,
  input  logic [XLEN-1:0]        retire_pc_i,
  input  logic [XLEN-1:0]        retire_instr_i,
  input  logic                   retire_rd_we_i,
  input  logic [XWIDTH-1:0]      retire_rd_i,
  input  logic [XLEN-1:0]        retire_rd_data_i,
  input  logic                   retire_mem_re_i,
  input  logic                   retire_mem_we_i,
  input  logic [XLEN-1:0]        retire_mem_addr_i,
  input  logic [XLEN-1:0]        retire_mem_data_i,
  output logic                   trace_valid_o,
  input  logic                   trace_ready_i,
  output logic [TRACE_REC_W-1:0] trace_rec_o,
  output logic                   stall_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  output logic                   halted_o
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 1);

  trace_state_e      state_q, state_d;
  logic [31:0]       seq_q,   seq_d;
  logic [CNT_W-1:0]  drop_q,  drop_d;

  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic              w_run;
  logic              w_push_req;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;

  // Build the outgoing record, zeroing fields that carry no information.
  always_comb begin
    w_rec          = '0;
    w_rec.seq      = seq_q;
    w_rec.pc       = retire_pc_i;
    w_rec.instr    = retire_instr_i;
    w_rec.rd_we    = retire_rd_we_i && (retire_rd_i != '0);
    w_rec.mem_re   = retire_mem_re_i;
    w_rec.mem_we   = retire_mem_we_i;
    w_rec.halt     = (retire_instr_i == '0);
    if (w_rec.rd_we) begin
      w_rec.rd      = retire_rd_i;
      w_rec.rd_data = retire_rd_data_i;
    end
    if (retire_mem_re_i || retire_mem_we_i) begin
      w_rec.mem_addr = retire_mem_addr_i;
      w_rec.mem_data = retire_mem_data_i;
    end
  end

  // Push/pop arbitration; a full FIFO still accepts when the head leaves now.
  assign w_push_req = retire_valid_i && enable_i && w_run;
  assign w_pop      = trace_valid_o && trace_ready_i;
  assign w_accept   = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  commit_trace_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .data_i  (w_rec),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign trace_valid_o = !w_empty;
  assign trace_rec_o   = w_head;
  // One slot stays free for the instruction already in flight in the core.
  assign stall_o       = (w_count >= STALL_LVL);
  assign drop_cnt_o    = drop_q;

  // Sequence number advances only on accepted records; drop count saturates.
  always_comb begin
    seq_d  = seq_q;
    drop_d = drop_q;
    if (w_accept) seq_d = seq_q + 32'd1;
    if (w_drop && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      seq_q  <= '0;
      drop_q <= '0;
    end else begin
      seq_q  <= seq_d;
      drop_q <= drop_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= TR_RUN;
    else         state_q <= state_d;
  end

  // FSM next state: an accepted halt record starts the drain; a dropped one
  // never reaches w_accept and so leaves the state alone.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TR_RUN:        if (w_accept && w_rec.halt) state_d = TR_HALT_DRAIN;
      TR_HALT_DRAIN: if (w_empty) state_d = TR_HALTED;
      TR_HALTED:     state_d = TR_HALTED;
      default:       state_d = TR_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    w_run    = (state_q == TR_RUN);
    halted_o = (state_q == TR_HALTED);
  end

endmodule : commit_trace_tx
`default_nettype wire
